// File: rtl/mem_arbiter.sv
// Two-requester block-memory arbiter: D-cache has fixed priority, and a bounded
// run of consecutive D grants keeps the I-cache from starving.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 128,
    parameter int D_MAX_CONSEC = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_busywait,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_ack,
    output logic [1:0]            grant
);

    localparam logic [3:0] C_MAX = 4'(D_MAX_CONSEC);

    // Encodings double as the debug grant value.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_I = 2'b01,
        ST_SERVE_D = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_consec_cnt;
    logic                  r_d_is_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_writedata;
    logic [DATA_WIDTH-1:0] r_i_readdata;
    logic [DATA_WIDTH-1:0] r_d_readdata;

    logic w_d_req;
    logic w_starve;
    logic w_grant_i;
    logic w_grant_d;
    logic w_ack_i;
    logic w_ack_d;

    assign w_d_req  = d_read | d_write;
    assign w_starve = i_read & (r_consec_cnt == C_MAX);
    assign w_ack_i  = (r_state == ST_SERVE_I) & mem_ack;
    assign w_ack_d  = (r_state == ST_SERVE_D) & mem_ack;

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_req && !w_starve) begin
                    w_state_next = ST_SERVE_D;
                    w_grant_d    = 1'b1;
                end else if (i_read) begin
                    w_state_next = ST_SERVE_I;
                    w_grant_i    = 1'b1;
                end
            end
            ST_SERVE_I: if (mem_ack) w_state_next = ST_RECOVER;
            ST_SERVE_D: if (mem_ack) w_state_next = ST_RECOVER;
            ST_RECOVER: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state         <= ST_IDLE;
            r_consec_cnt    <= '0;
            r_d_is_write    <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_i_readdata    <= '0;
            r_d_readdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_d) begin
                r_mem_address   <= d_address;
                r_mem_writedata <= d_writedata;
                // A simultaneous read+write is treated as a write-back.
                r_d_is_write    <= d_write;
                if (i_read)
                    r_consec_cnt <= (r_consec_cnt >= C_MAX) ? C_MAX : r_consec_cnt + 4'd1;
                else
                    r_consec_cnt <= '0;
            end
            if (w_grant_i) begin
                r_mem_address <= i_address;
                r_consec_cnt  <= '0;
            end
            if (w_ack_i) r_i_readdata <= mem_readdata;
            if (w_ack_d) r_d_readdata <= mem_readdata;
        end
    end

    assign mem_read      = (r_state == ST_SERVE_I) | ((r_state == ST_SERVE_D) & ~r_d_is_write);
    assign mem_write     = (r_state == ST_SERVE_D) & r_d_is_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;
    assign grant         = r_state;

    // Caches see the ack-cycle data immediately; the register keeps it afterwards.
    assign i_busywait = i_read & ~w_ack_i;
    assign d_busywait = w_d_req & ~w_ack_d;
    assign i_readdata = w_ack_i ? mem_readdata : r_i_readdata;
    assign d_readdata = w_ack_d ? mem_readdata : r_d_readdata;

endmodule
